// File: rtl/fog_param_bank_pkg.sv
// Shared constants for the FOG parameter bank: register map, per-register reset defaults,
// legal write ranges and the per-channel commit FSM state type.
package fog_param_pkg;

  localparam int         PKG_DATA_W = 32;
  localparam int         N_REG      = 11;
  localparam logic [3:0] STATUS_IDX = 4'd15;

  typedef enum logic [3:0] {
    REG_FREQ_CNT   = 4'd0,
    REG_AMP_H      = 4'd1,
    REG_AMP_L      = 4'd2,
    REG_POLARITY   = 4'd3,
    REG_WAIT_CNT   = 4'd4,
    REG_ERR_OFFSET = 4'd5,
    REG_AVG_SEL    = 4'd6,
    REG_GAIN_STEP  = 4'd7,
    REG_GAIN_RAMP  = 4'd8,
    REG_FB_ON      = 4'd9,
    REG_CONST_STEP = 4'd10
  } reg_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY
  } ch_state_t;

  localparam logic [PKG_DATA_W-1:0] DEFAULTS [N_REG] = '{
    32'd1000, 32'd5000, 32'd5000, 32'd0, 32'd50, 32'd0,
    32'd10, 32'd5, 32'd10, 32'd1, 32'd100
  };

  // ERR_OFFSET bounds are two's complement (-32768 .. 32767); all others are unsigned
  localparam logic [PKG_DATA_W-1:0] MIN [N_REG] = '{
    32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_8000,
    32'd0, 32'd0, 32'd0, 32'd0, 32'd0
  };

  localparam logic [PKG_DATA_W-1:0] MAX [N_REG] = '{
    32'd65535, 32'd65535, 32'd65535, 32'd1, 32'd1023, 32'h0000_7FFF,
    32'd15, 32'd31, 32'd255, 32'd1, 32'd65535
  };

endpackage

// File: rtl/fog_param_bank_channel.sv
// One channel of the parameter bank: shadow/active register sets, commit FSM with
// boundary-or-timeout apply, and the dirty/applied/timeout status flags.
module fog_param_channel
  import fog_param_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                    CLOCK_CPU,
  input  logic                    RST_SYNC_N,
  input  logic                    wr_en,
  input  logic [3:0]              wr_idx,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    commit,
  input  logic                    boundary,
  input  logic                    status_clr,
  output logic [N_REG*DATA_W-1:0] active_flat,
  output logic [N_REG*DATA_W-1:0] shadow_flat,
  output logic                    pending,
  output logic                    dirty,
  output logic                    applied,
  output logic                    timeout
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [DATA_W-1:0] shadow [N_REG];
  logic [DATA_W-1:0] active [N_REG];

  ch_state_t        state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             to_set;

  // Active copies the pre-write shadow, so a write landing in the APPLY cycle stays shadow-only
  always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
    if (!RST_SYNC_N) begin
      for (int r = 0; r < N_REG; r++) begin
        shadow[r] <= DATA_W'(DEFAULTS[r]);
        active[r] <= DATA_W'(DEFAULTS[r]);
      end
    end else begin
      if (state == APPLY) begin
        for (int r = 0; r < N_REG; r++) active[r] <= shadow[r];
      end
      if (wr_en) begin
        for (int r = 0; r < N_REG; r++) begin
          if (32'(wr_idx) == r) shadow[r] <= wr_data;
        end
      end
    end
  end

  for (genvar r = 0; r < N_REG; r++) begin : g_flat
    assign active_flat[r*DATA_W +: DATA_W] = active[r];
    assign shadow_flat[r*DATA_W +: DATA_W] = shadow[r];
  end

  always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
    if (!RST_SYNC_N) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // A boundary arriving with the commit is ignored: IDLE only looks at commit
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    to_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (commit) begin
          state_nxt = PENDING;
          timer_nxt = '0;
        end
      end
      PENDING: begin
        timer_nxt = timer + TMR_W'(1);
        if (boundary) begin
          state_nxt = APPLY;
        end else if (timer == TMR_LAST) begin
          state_nxt = APPLY;
          to_set    = 1'b1;
        end
      end
      APPLY: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pending = (state == PENDING);

  always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
    if (!RST_SYNC_N) begin
      dirty   <= 1'b0;
      applied <= 1'b0;
      timeout <= 1'b0;
    end else begin
      applied <= (state == APPLY);
      if (wr_en)                dirty <= 1'b1;
      else if (state == APPLY)  dirty <= 1'b0;
      if (to_set)               timeout <= 1'b1;
      else if (status_clr)      timeout <= 1'b0;
    end
  end

endmodule

// File: rtl/fog_param_bank.sv
// Multi-channel FOG parameter bank: write decode, registered read mux and flattened active
// parameters. Define FOG_PARAM_RANGE_CHECK_EN to reject writes outside the per-register MIN/MAX.
module fog_param_bank
  import fog_param_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int ADDR_W      = CH_W + 5
) (
  input  logic                         CLOCK_CPU,
  input  logic                         RST_SYNC_N,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic                         i_rd_en,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic                         o_rd_valid,
  input  logic [N_CH-1:0]              i_commit,
  input  logic [N_CH-1:0]              i_boundary,
  output logic [N_CH*N_REG*DATA_W-1:0] o_params,
  output logic [N_CH-1:0]              o_pending,
  output logic [N_CH-1:0]              o_dirty,
  output logic [N_CH-1:0]              o_applied,
  output logic [N_CH-1:0]              o_timeout,
  output logic                         o_wr_err
);

  function automatic logic in_range(input logic [3:0] idx, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0]        lo, hi;
    logic signed [DATA_W-1:0] sd, slo, shi;
    logic                     ok;
    ok = 1'b0;
    for (int r = 0; r < N_REG; r++) begin
      if (32'(idx) == r) begin
        lo = DATA_W'(MIN[r]);
        hi = DATA_W'(MAX[r]);
        if (r == int'(REG_ERR_OFFSET)) begin
          sd  = d;
          slo = lo;
          shi = hi;
          ok  = (sd >= slo) && (sd <= shi);
        end else begin
          ok = (d >= lo) && (d <= hi);
        end
      end
    end
    return ok;
  endfunction

  logic [CH_W-1:0] wr_ch, rd_ch;
  logic [3:0]      wr_idx, rd_idx;
  logic            rd_shd;
  logic            addr_ok, data_ok, wr_ok;
  logic            unused_wr_sel;

  assign wr_ch         = i_wr_addr[ADDR_W-1 -: CH_W];
  assign wr_idx        = i_wr_addr[3:0];
  assign unused_wr_sel = i_wr_addr[4];
  assign rd_ch         = i_rd_addr[ADDR_W-1 -: CH_W];
  assign rd_shd        = i_rd_addr[4];
  assign rd_idx        = i_rd_addr[3:0];

  assign addr_ok = (32'(wr_ch) < N_CH) && (32'(wr_idx) < N_REG);
`ifdef FOG_PARAM_RANGE_CHECK_EN
  assign data_ok = in_range(wr_idx, i_wr_data);
`else
  assign data_ok = 1'b1;
`endif
  assign wr_ok = i_wr_en && addr_ok && data_ok;

  logic [N_CH-1:0]         ch_wr, ch_clr;
  logic [N_REG*DATA_W-1:0] act_bus [N_CH];
  logic [N_REG*DATA_W-1:0] shd_bus [N_CH];

  always_comb begin
    ch_wr  = '0;
    ch_clr = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_wr[c]  = wr_ok && (32'(wr_ch) == c);
      ch_clr[c] = i_rd_en && (32'(rd_ch) == c) && (rd_idx == STATUS_IDX);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    fog_param_channel #(
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ch (
      .CLOCK_CPU   (CLOCK_CPU),
      .RST_SYNC_N  (RST_SYNC_N),
      .wr_en       (ch_wr[c]),
      .wr_idx      (wr_idx),
      .wr_data     (i_wr_data),
      .commit      (i_commit[c]),
      .boundary    (i_boundary[c]),
      .status_clr  (ch_clr[c]),
      .active_flat (act_bus[c]),
      .shadow_flat (shd_bus[c]),
      .pending     (o_pending[c]),
      .dirty       (o_dirty[c]),
      .applied     (o_applied[c]),
      .timeout     (o_timeout[c])
    );
    assign o_params[c*N_REG*DATA_W +: N_REG*DATA_W] = act_bus[c];
  end

  // Read select: status reflects pre-clear flags since the clear lands on the capture edge
  logic [DATA_W-1:0] rd_sel_p0;

  always_comb begin
    rd_sel_p0 = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (32'(rd_ch) == c) begin
        if (rd_idx == STATUS_IDX) begin
          rd_sel_p0 = DATA_W'({o_timeout[c], o_dirty[c], o_pending[c], 1'b1});
        end else begin
          for (int r = 0; r < N_REG; r++) begin
            if (32'(rd_idx) == r) begin
              rd_sel_p0 = rd_shd ? shd_bus[c][r*DATA_W +: DATA_W]
                                 : act_bus[c][r*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  end

  // Stage p1: registered read data, valid and write-error pulse
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1, wr_err_p1;

  always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
    if (!RST_SYNC_N) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      wr_err_p1  <= 1'b0;
    end else begin
      vld_p1    <= i_rd_en;
      wr_err_p1 <= i_wr_en && !(addr_ok && data_ok);
      if (i_rd_en) rd_data_p1 <= rd_sel_p0;
    end
  end

  assign o_rd_data  = rd_data_p1;
  assign o_rd_valid = vld_p1;
  assign o_wr_err   = wr_err_p1;

endmodule
